mod_step_counter: RTL and testbench
===================================

// Module: mod_step_counter
// PURPOSE
//  Parametrised up/down counter with programmable step, programmable modulo limit and wrap/saturate mode.
//  Synchronous load with clamping. Registered wrap-event pulse.
//  General-purpose timebase/sequencer counter for lab datapaths; drives displays, timers and address generators.
// PARAMETERS
//  WIDTH       8  counter, step, limit and load-value width
//  PRESCALE_W  4  prescaler width (used only when COUNTER_PRESCALE_EN is defined)
// PORTS
//  clk      in   1           rising-edge clock
//  rst      in   1           synchronous, active-high reset
//  en       in   1           count enable (one step per enabled cycle)
//  ld       in   1           synchronous load of v
//  v        in   WIDTH       load value
//  up       in   1           1 = count up, 0 = count down
//  sat      in   1           1 = saturate at bounds, 0 = wrap
//  step     in   WIDTH       increment/decrement amount (0 = hold)
//  limit    in   WIDTH       inclusive upper bound; legal range 0..limit
//  div      in   PRESCALE_W  prescale divisor-1 (present only with COUNTER_PRESCALE_EN)
//  count    out  WIDTH       current count (registered)
//  at_bound out  1           combinational: up ? (count==limit) : (count==0)
//  wrapped  out  1           registered 1-cycle pulse; wrap or saturation event occurred on previous edge
// BEHAVIOUR
//  - Reset: count=0, wrapped=0, prescaler=0. Priority rst > ld > en.
//  - ld: count <= (v > limit) ? limit : v; wrapped <= 0; en is ignored that cycle.
//  - en=0 and ld=0: count holds; wrapped <= 0.
//  - All arithmetic is done in WIDTH+1 bits; no silent truncation.
//  - Up step: s = count + step.
//    - If s <= limit: count <= s.
//    - Otherwise (overflow): wrap mode count <= 0; sat mode count <= limit. wrapped <= 1 in both modes.
//  - Down step:
//    - If count >= step: count <= count - step.
//    - Otherwise (underflow): wrap mode count <= limit; sat mode count <= 0. wrapped <= 1.
//  - Already saturated (sat=1, at bound, step>0): count holds and wrapped <= 1 on every enabled step.
//  - step=0: count holds; wrapped <= 0, except when count > limit (next rule).
//  - limit changed below current count: the next enabled step is treated as a bound event, regardless of step.
//    - up: wrap -> 0, sat -> limit.
//    - down: count <= limit.
//    - wrapped <= 1.
//  - limit=0: count is pinned to 0. Every enabled step with step>0 is a bound event.
//  - Latency: count updates on the edge where en/ld is sampled. wrapped is valid on the cycle after the event.
//  - up, sat, step and limit are sampled each enabled cycle and may change at any time.
// CONFIGURATION
//  - COUNTER_PRESCALE_EN defined:
//    - Adds input div and a PRESCALE_W-bit prescaler.
//    - On en=1, the prescaler increments. A step is taken only on the enabled cycle where prescaler==div; the prescaler then clears to 0.
//    - en=0 holds the prescaler. rst and ld clear the prescaler.
//    - div=0 gives behaviour identical to the non-prescaled build.
//  - COUNTER_PRESCALE_EN undefined:
//    - No div port, no prescaler.
//    - Every cycle with en=1 takes one step.
// TESTING
//  1. rst=1 for 2 cycles with en=1, ld=1 -> count=0, wrapped=0, at_bound=1 (up=1, limit=0).
//  2. WIDTH=8, limit=9, step=1, up=1, sat=0, en=1 for 12 cycles from 0 -> 1..9,0,1,2.
//     wrapped high for exactly 1 cycle, after the 9->0 edge. at_bound high while count==9.
//  3. limit=200, step=60, up=1, sat=1, start 150 -> 200, then holds at 200 with wrapped=1 each enabled cycle.
//     Switch up=0 -> 140, 80, 20, 0 (saturates at 0, wrapped=1).
//  4. limit=255, step=255, up=1, sat=0, count=1 -> s=256 overflows to 0 (no 8-bit truncation to 0 via the s<=limit path).
//     ld=1, v=255 -> count=255.
//  5. limit=50, ld=1, v=80 -> count=50. Then limit=20, en=1, up=1, sat=0 -> count=0, wrapped=1.
//     Simultaneous ld=1, en=1, v=7 -> count=7, wrapped=0.
//  6. COUNTER_PRESCALE_EN, div=3, step=1, limit=255, en=1 -> count advances on every 4th enabled cycle.
//     Deassert en for 2 cycles mid-period -> no step and prescaler holds. ld=1 -> prescaler restarts at 0.

Source files
------------

// File: rtl/mod_step_counter.sv
// Up/down modulo counter with programmable step, inclusive limit, wrap/saturate and a wrap pulse.
// Defining COUNTER_PRESCALE_EN adds the div input and an enable prescaler.
module mod_step_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ld,
  input  logic [WIDTH-1:0]      v,
  input  logic                  up,
  input  logic                  sat,
  input  logic [WIDTH-1:0]      step,
  input  logic [WIDTH-1:0]      limit,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] div,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  at_bound,
  output logic                  wrapped
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic             tick;

  // Extra carry bit keeps count + step from aliasing back into range.
  logic [WIDTH:0] sum;
  logic           overflow;
  logic           underflow;
  logic           out_of_range;

  assign sum          = {1'b0, count_q} + {1'b0, step};
  assign overflow     = sum > {1'b0, limit};
  assign underflow    = count_q < step;
  assign out_of_range = count_q > limit;

`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc_q, presc_d;

  assign tick = (presc_q == div);

  always_comb begin
    presc_d = presc_q;
    if (ld) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    count_d   = count_q;
    wrapped_d = 1'b0;
    if (ld) begin
      count_d = (v > limit) ? limit : v;
    end else if (en && tick) begin
      if (out_of_range) begin
        // Limit dropped under the count: force a bound event whatever the step.
        wrapped_d = 1'b1;
        count_d   = (up && !sat) ? '0 : limit;
      end else if (step == '0) begin
        count_d = count_q;
      end else if (up) begin
        if (overflow) begin
          wrapped_d = 1'b1;
          count_d   = sat ? limit : '0;
        end else begin
          count_d = sum[WIDTH-1:0];
        end
      end else begin
        if (underflow) begin
          wrapped_d = 1'b1;
          count_d   = sat ? '0 : limit;
        end else begin
          count_d = count_q - step;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count    = count_q;
  assign wrapped  = wrapped_q;
  assign at_bound = up ? (count_q == limit) : (count_q == '0);

endmodule

// File: tb/tb_mod_step_counter.sv
// Directed and randomized bench for mod_step_counter against an integer reference model.
module tb_mod_step_counter;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst, en, ld, up, sat;
  logic [W-1:0]  v, step, limit;
  logic [PW-1:0] div;
  logic [W-1:0]  count;
  logic          at_bound, wrapped;

  int checks = 0;
  int errors = 0;
  int m_c = 0, m_w = 0, m_p = 0;

  always #5 clk = ~clk;

  mod_step_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ld       (ld),
    .v        (v),
    .up       (up),
    .sat      (sat),
    .step     (step),
    .limit    (limit),
`ifdef COUNTER_PRESCALE_EN
    .div      (div),
`endif
    .count    (count),
    .at_bound (at_bound),
    .wrapped  (wrapped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock: predict the next state from the rules, then compare.
  task automatic cyc(input string tag);
    int c, w, p, s, lim, st;
    bit take;
    c    = m_c;
    w    = 0;
    p    = m_p;
    lim  = int'(limit);
    st   = int'(step);
    take = 1'b0;
    if (rst) begin
      c = 0;
      p = 0;
    end else if (ld) begin
      c = (int'(v) > lim) ? lim : int'(v);
      p = 0;
    end else if (en) begin
`ifdef COUNTER_PRESCALE_EN
      if (p != int'(div)) p = (p + 1) % (1 << PW);
      else begin
        p    = 0;
        take = 1'b1;
      end
`else
      take = 1'b1;
`endif
    end
    if (take) begin
      if (c > lim) begin
        w = 1;
        c = (up && !sat) ? 0 : lim;
      end else if (st == 0) begin
        w = 0;
      end else if (up) begin
        s = c + st;
        if (s <= lim) c = s;
        else begin
          c = sat ? lim : 0;
          w = 1;
        end
      end else begin
        if (c >= st) c = c - st;
        else begin
          c = sat ? 0 : lim;
          w = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    m_c = c;
    m_w = w;
    m_p = p;
    chk({tag, " count"}, 32'(count), 32'(c));
    chk({tag, " wrapped"}, 32'(wrapped), 32'(w));
    chk({tag, " at_bound"}, 32'(at_bound), up ? 32'(c == lim) : 32'(c == 0));
  endtask

  int exp2 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp3 [7]  = '{200, 200, 200, 140, 80, 20, 0};
  int expw3 [7] = '{1, 1, 1, 0, 0, 0, 1};

  initial begin
    rst = 1'b1; en = 1'b1; ld = 1'b1; up = 1'b1; sat = 1'b0;
    v = 8'd5; step = 8'd1; limit = 8'd0; div = '0;

    // Reset dominates ld and en.
    cyc("rst");
    cyc("rst");
    chk("rst count", 32'(count), 0);
    chk("rst wrapped", 32'(wrapped), 0);
    chk("rst at_bound", 32'(at_bound), 1);

    // Modulo-10 wrap.
    rst = 1'b0; ld = 1'b0; limit = 8'd9;
    for (int i = 0; i < 12; i++) begin
      cyc("mod10");
      chk("mod10 const count", 32'(count), 32'(exp2[i]));
      chk("mod10 const wrapped", 32'(wrapped), 32'(i == 9));
      chk("mod10 const at_bound", 32'(at_bound), 32'(exp2[i] == 9));
    end

    // Saturation at both bounds.
    en = 1'b0; ld = 1'b1; v = 8'd150; limit = 8'd200;
    cyc("sat ld");
    ld = 1'b0; en = 1'b1; step = 8'd60; sat = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) up = 1'b0;
      cyc("sat");
      chk("sat const count", 32'(count), 32'(exp3[i]));
      chk("sat const wrapped", 32'(wrapped), 32'(expw3[i]));
    end

    // Full-width overflow must not alias through the in-range path.
    en = 1'b0; ld = 1'b1; v = 8'd1; limit = 8'd255; step = 8'd255; up = 1'b1; sat = 1'b0;
    cyc("wide ld");
    ld = 1'b0; en = 1'b1;
    cyc("wide ovf");
    chk("wide const count", 32'(count), 0);
    chk("wide const wrapped", 32'(wrapped), 1);
    en = 1'b0; ld = 1'b1; v = 8'd255;
    cyc("wide ld255");
    chk("wide ld255 const", 32'(count), 255);

    // Load clamp, limit lowered under count, ld beats en.
    limit = 8'd50; v = 8'd80;
    cyc("clamp");
    chk("clamp const", 32'(count), 50);
    ld = 1'b0; limit = 8'd20; en = 1'b1; step = 8'd1;
    cyc("limdrop");
    chk("limdrop const count", 32'(count), 0);
    chk("limdrop const wrapped", 32'(wrapped), 1);
    ld = 1'b1; v = 8'd7;
    cyc("ld_en");
    chk("ld_en const count", 32'(count), 7);
    chk("ld_en const wrapped", 32'(wrapped), 0);

`ifdef COUNTER_PRESCALE_EN
    // Divide-by-4 enable, hold while disabled, restart on ld.
    en = 1'b0; ld = 1'b1; v = 8'd0; limit = 8'd255; step = 8'd1; div = 4'd3;
    cyc("pre ld");
    ld = 1'b0; en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc("pre run");
      chk("pre const count", 32'(count), 32'(i / 4));
    end
    en = 1'b0;
    cyc("pre hold");
    cyc("pre hold");
    en = 1'b1;
    cyc("pre resume");
    chk("pre resume const", 32'(count), 2);
    cyc("pre resume");
    chk("pre resume const", 32'(count), 3);
    ld = 1'b1; v = 8'd0;
    cyc("pre reld");
    ld = 1'b0;
    for (int i = 1; i <= 4; i++) cyc("pre restart");
    chk("pre restart const", 32'(count), 1);
    div = '0;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 3) != 0);
      up  = $urandom_range(0, 1) != 0;
      sat = $urandom_range(0, 1) != 0;
      v   = 8'($urandom);
      step = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0)
        limit = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
`ifdef COUNTER_PRESCALE_EN
      if ($urandom_range(0, 31) == 0) div = 4'($urandom_range(0, 3));
`endif
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
